// File: rtl/ramctrl.sv
// ramctrl: arbitrates data and instruction-fetch requests onto a byte-serial
// synchronous RAM bus. It splits accesses into little-endian bytes, reassembles
// and extends read data, and returns one-cycle ready pulses.
module ramctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_rst_in,
  input  logic        datactrl_ramctrl_data_en_in,
  input  logic        datactrl_ramctrl_data_rw_in,
  input  logic        datactrl_ramctrl_data_sgn_in,
  input  logic [2:0]  datactrl_ramctrl_data_width_in,
  input  logic [31:0] datactrl_ramctrl_data_addr_in,
  input  logic [31:0] datactrl_ramctrl_data_data_in,
  output logic        ramctrl_datactrl_data_rdy_out,
  output logic [31:0] ramctrl_datactrl_data_data_out,
  input  logic        icache_ramctrl_en_in,
  input  logic [31:0] icache_ramctrl_addr_in,
  output logic        ramctrl_icache_en_out,
  output logic [31:0] ramctrl_icache_data_out,
  input  logic [7:0]  ram_data_in,
  output logic [7:0]  ram_data_out,
  output logic [31:0] ram_addr_out,
  output logic        ram_rw_out
);

  localparam int unsigned AddressWidth = 32;
  localparam int unsigned IDWidth      = 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e                  state_q, state_d;
  logic                    src_q, src_d;      // 1 = data port, 0 = fetch port
  logic                    sgn_q, sgn_d;
  logic [2:0]              len_q, len_d;      // byte count 1, 2 or 4
  logic [2:0]              cnt_q, cnt_d;      // edges since acceptance
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [IDWidth-1:0]      wdata_q, wdata_d;
  logic [IDWidth-1:0]      rbuf_q, rbuf_d;
  logic [AddressWidth-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]              ram_data_q, ram_data_d;
  logic                    ram_rw_q, ram_rw_d;
  logic                    d_rdy_q, d_rdy_d;
  logic [IDWidth-1:0]      d_data_q, d_data_d;
  logic                    i_rdy_q, i_rdy_d;
  logic [IDWidth-1:0]      i_data_q, i_data_d;

  logic                    acc_rw;
  logic [2:0]              idx;
  logic [IDWidth-1:0]      merged;

  // Next-state, byte sequencing and read reassembly
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    sgn_d      = sgn_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_rw_d   = ram_rw_q;
    d_rdy_d    = 1'b0;
    d_data_d   = d_data_q;
    i_rdy_d    = 1'b0;
    i_data_d   = i_data_q;
    acc_rw     = 1'b0;
    idx        = cnt_q - 3'd2;
    merged     = '0;

    unique case (state_q)
      IDLE: begin
        if (!rob_rst_in && (datactrl_ramctrl_data_en_in || icache_ramctrl_en_in)) begin
          if (datactrl_ramctrl_data_en_in) begin
            src_d   = 1'b1;
            acc_rw  = datactrl_ramctrl_data_rw_in;
            sgn_d   = datactrl_ramctrl_data_sgn_in;
            addr_d  = datactrl_ramctrl_data_addr_in;
            wdata_d = datactrl_ramctrl_data_data_in;
            unique case (datactrl_ramctrl_data_width_in)
              3'd1:    len_d = 3'd1;
              3'd2:    len_d = 3'd2;
              default: len_d = 3'd4;
            endcase
          end else begin
            src_d  = 1'b0;
            acc_rw = 1'b0;
            sgn_d  = 1'b0;
            len_d  = 3'd4;
            addr_d = icache_ramctrl_addr_in;
          end
          cnt_d      = 3'd1;
          rbuf_d     = '0;
          ram_addr_d = addr_d;
          if (acc_rw) begin
            ram_rw_d   = 1'b1;
            ram_data_d = wdata_d[7:0];
            state_d    = WRITE;
          end else begin
            ram_rw_d = 1'b0;
            state_d  = READ;
          end
        end
      end

      // Committed store: a flush never interrupts it
      WRITE: begin
        if (cnt_q < len_q) begin
          ram_addr_d = addr_q + AddressWidth'(cnt_q);
          ram_data_d = 8'(wdata_q >> {cnt_q, 3'b000});
          cnt_d      = cnt_q + 3'd1;
        end else begin
          ram_rw_d = 1'b0;
          d_rdy_d  = 1'b1;
          state_d  = DONE;
        end
      end

      READ: begin
        if (rob_rst_in) begin
          ram_rw_d = 1'b0;
          state_d  = IDLE;
        end else begin
          if (cnt_q < len_q) begin
            ram_addr_d = addr_q + AddressWidth'(cnt_q);
          end
          cnt_d = cnt_q + 3'd1;
          if (cnt_q >= 3'd2) begin
            merged = rbuf_q | (IDWidth'(ram_data_in) << {idx[1:0], 3'b000});
            if (cnt_q == len_q + 3'd1) begin
              if (sgn_q && src_q) begin
                if (len_q == 3'd1 && merged[7])  merged[31:8]  = '1;
                if (len_q == 3'd2 && merged[15]) merged[31:16] = '1;
              end
              if (src_q) begin
                d_data_d = merged;
                d_rdy_d  = 1'b1;
              end else begin
                i_data_d = merged;
                i_rdy_d  = 1'b1;
              end
              state_d = DONE;
            end else begin
              rbuf_d = merged;
            end
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; clock-enabled by rdy_in
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      src_q      <= 1'b0;
      sgn_q      <= 1'b0;
      len_q      <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_rw_q   <= 1'b0;
      d_rdy_q    <= 1'b0;
      d_data_q   <= '0;
      i_rdy_q    <= 1'b0;
      i_data_q   <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      src_q      <= src_d;
      sgn_q      <= sgn_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_rw_q   <= ram_rw_d;
      d_rdy_q    <= d_rdy_d;
      d_data_q   <= d_data_d;
      i_rdy_q    <= i_rdy_d;
      i_data_q   <= i_data_d;
    end
  end

  assign ramctrl_datactrl_data_rdy_out  = d_rdy_q;
  assign ramctrl_datactrl_data_data_out = d_data_q;
  assign ramctrl_icache_en_out          = i_rdy_q;
  assign ramctrl_icache_data_out        = i_data_q;
  assign ram_data_out                   = ram_data_q;
  assign ram_addr_out                   = ram_addr_q;
  assign ram_rw_out                     = ram_rw_q;

endmodule

// File: tb/tb_ramctrl.sv
// Directed bench for ramctrl with a synchronous byte RAM model.
module tb_ramctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        rob_rst_in = 1'b0;
  logic        d_en = 1'b0, d_rw = 1'b0, d_sgn = 1'b0;
  logic [2:0]  d_width = 3'd4;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_rdy;
  logic [31:0] d_rdata;
  logic        ic_en = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_rdy;
  logic [31:0] ic_data;
  logic [7:0]  ram_q = '0;
  logic [7:0]  ram_wd;
  logic [31:0] ram_a;
  logic        ram_rw;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:4095];

  ramctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_rst_in(rob_rst_in),
    .datactrl_ramctrl_data_en_in(d_en), .datactrl_ramctrl_data_rw_in(d_rw),
    .datactrl_ramctrl_data_sgn_in(d_sgn), .datactrl_ramctrl_data_width_in(d_width),
    .datactrl_ramctrl_data_addr_in(d_addr), .datactrl_ramctrl_data_data_in(d_wdata),
    .ramctrl_datactrl_data_rdy_out(d_rdy), .ramctrl_datactrl_data_data_out(d_rdata),
    .icache_ramctrl_en_in(ic_en), .icache_ramctrl_addr_in(ic_addr),
    .ramctrl_icache_en_out(ic_rdy), .ramctrl_icache_data_out(ic_data),
    .ram_data_in(ram_q), .ram_data_out(ram_wd), .ram_addr_out(ram_a), .ram_rw_out(ram_rw)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM, stalled by rdy_in; preloaded during reset
  always @(posedge clk_in) begin
    if (rst_in) begin
      mem[12'h200] <= 8'h80;
      mem[12'h300] <= 8'h80;
      mem[12'h301] <= 8'h01;
      mem[12'h302] <= 8'h80;
      mem[12'h400] <= 8'h13;
      mem[12'h401] <= 8'h00;
      mem[12'h402] <= 8'h00;
      mem[12'h403] <= 8'h00;
    end else if (rdy_in) begin
      if (ram_rw) mem[ram_a[11:0]] <= ram_wd;
      ram_q <= mem[ram_a[11:0]];
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Drive one data request; j counts edges from acceptance (E0 = first tick)
  task automatic do_req(input logic rw, input logic sgn, input logic [2:0] w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int rdy_edge, output int rdy_cnt, output int rw_cnt,
                        output logic [31:0] res);
    d_rw = rw; d_sgn = sgn; d_width = w; d_addr = a; d_wdata = d; d_en = 1'b1;
    rdy_edge = -1; rdy_cnt = 0; rw_cnt = 0; res = '0;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (ram_rw) rw_cnt++;
      if (d_rdy) begin
        rdy_cnt++;
        if (rdy_edge < 0) begin
          rdy_edge = j; res = d_rdata; d_en = 1'b0;
        end
      end
      if (rdy_edge >= 0 && j == rdy_edge + 2) break;
    end
    d_en = 1'b0;
  endtask

  task automatic test_reset();
    d_en = 1'b1; d_rw = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF; ic_en = 1'b1;
    ic_addr = 32'h400;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++;
      if ({ram_rw, d_rdy, ic_rdy, ram_wd, ram_a, d_rdata, ic_data} !== '0) begin
        fails++;
        $display("FAIL reset_outputs: rw=%b drdy=%b irdy=%b wd=%h a=%h dd=%h id=%h, want all 0",
                 ram_rw, d_rdy, ic_rdy, ram_wd, ram_a, d_rdata, ic_data);
      end
    end
    d_en = 1'b0; ic_en = 1'b0; rst_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_write();
    int e, c, r; logic [31:0] v;
    do_req(1'b1, 1'b0, 3'd4, 32'h100, 32'h12345678, e, c, r, v);
    tests++;
    if (e !== 4) begin fails++; $display("FAIL write_rdy_edge: got %0d want 4", e); end
    tests++;
    if (c !== 1) begin fails++; $display("FAIL write_rdy_width: got %0d want 1", c); end
    tests++;
    if (r !== 4) begin fails++; $display("FAIL write_rw_cycles: got %0d want 4", r); end
    tests++;
    if ({mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]} !== 32'h12345678) begin
      fails++;
      $display("FAIL write_bytes: got %h%h%h%h want 12345678",
               mem[12'h103], mem[12'h102], mem[12'h101], mem[12'h100]);
    end
  endtask

  task automatic test_read();
    int e, c, r; logic [31:0] v;
    do_req(1'b0, 1'b1, 3'd1, 32'h200, '0, e, c, r, v);
    tests++;
    if (v !== 32'hFFFFFF80 || e !== 2) begin
      fails++; $display("FAIL read_byte_signed: got %h@E%0d want ffffff80@E2", v, e);
    end
    do_req(1'b0, 1'b0, 3'd1, 32'h200, '0, e, c, r, v);
    tests++;
    if (v !== 32'h00000080 || e !== 2) begin
      fails++; $display("FAIL read_byte_unsigned: got %h@E%0d want 00000080@E2", v, e);
    end
    do_req(1'b0, 1'b1, 3'd2, 32'h300, '0, e, c, r, v);
    tests++;
    if (v !== 32'h00000180 || e !== 3 || c !== 1) begin
      fails++; $display("FAIL read_half_pos: got %h@E%0d x%0d want 00000180@E3 x1", v, e, c);
    end
    do_req(1'b0, 1'b1, 3'd2, 32'h301, '0, e, c, r, v);
    tests++;
    if (v !== 32'hFFFF8001 || e !== 3) begin
      fails++; $display("FAIL read_half_neg: got %h@E%0d want ffff8001@E3", v, e);
    end
    do_req(1'b0, 1'b0, 3'd4, 32'h100, '0, e, c, r, v);
    tests++;
    if (v !== 32'h12345678 || e !== 5 || r !== 0) begin
      fails++; $display("FAIL read_word: got %h@E%0d rw=%0d want 12345678@E5 rw=0", v, e, r);
    end
  endtask

  task automatic test_arbitration();
    int de = -1, ie = -1, icnt = 0;
    logic [31:0] iv = '0;
    d_rw = 1'b0; d_sgn = 1'b0; d_width = 3'd1; d_addr = 32'h200; d_en = 1'b1;
    ic_addr = 32'h400; ic_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      tick();
      if (d_rdy && de < 0) begin de = j; d_en = 1'b0; end
      if (ic_rdy) begin
        icnt++;
        if (ie < 0) begin ie = j; iv = ic_data; ic_en = 1'b0; end
      end
      if (ie >= 0 && j == ie + 2) break;
    end
    d_en = 1'b0; ic_en = 1'b0;
    tests++;
    if (de !== 2) begin fails++; $display("FAIL arb_data_first: data rdy E%0d want E2", de); end
    tests++;
    if (ie !== 9 || iv !== 32'h00000013) begin
      fails++; $display("FAIL arb_fetch: got %h@E%0d want 00000013@E9", iv, ie);
    end
    tests++;
    if (icnt !== 1) begin fails++; $display("FAIL fetch_pulse_width: got %0d want 1", icnt); end
    tests++;
    if (d_rdata !== 32'h00000080) begin
      fails++; $display("FAIL data_hold: got %h want 00000080", d_rdata);
    end
  endtask

  task automatic test_flush();
    int rdy_seen = 0, rw_seen = 0, e = -1;
    logic [31:0] v = '0;
    // Flush a word read at E2, then issue a byte read accepted at E3
    d_rw = 1'b0; d_sgn = 1'b0; d_width = 3'd4; d_addr = 32'h100; d_en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (ram_rw) rw_seen++;
      if (d_rdy) begin
        if (j < 5) rdy_seen++;
        if (e < 0) begin e = j; v = d_rdata; d_en = 1'b0; end
      end
      if (j == 1) rob_rst_in = 1'b1;
      if (j == 2) begin rob_rst_in = 1'b0; d_width = 3'd1; d_addr = 32'h200; end
      if (e >= 0 && j == e + 2) break;
    end
    d_en = 1'b0;
    tests++;
    if (rdy_seen !== 0 || rw_seen !== 0) begin
      fails++; $display("FAIL flush_read_abort: rdy=%0d rw=%0d want 0 0", rdy_seen, rw_seen);
    end
    tests++;
    if (e !== 5 || v !== 32'h00000080) begin
      fails++; $display("FAIL flush_next_req: got %h@E%0d want 00000080@E5", v, e);
    end
    // Flush at E1 of a word write must not stop it
    e = -1; rw_seen = 0; rdy_seen = 0;
    d_rw = 1'b1; d_width = 3'd4; d_addr = 32'h500; d_wdata = 32'hA1B2C3D4; d_en = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (ram_rw) rw_seen++;
      if (d_rdy) begin rdy_seen++; if (e < 0) begin e = j; d_en = 1'b0; end end
      rob_rst_in = (j == 0);
      if (e >= 0 && j == e + 2) break;
    end
    rob_rst_in = 1'b0; d_en = 1'b0;
    tests++;
    if (e !== 4 || rdy_seen !== 1 || rw_seen !== 4) begin
      fails++; $display("FAIL flush_write: rdy@E%0d x%0d rw=%0d want E4 x1 rw=4", e, rdy_seen, rw_seen);
    end
    tests++;
    if ({mem[12'h503], mem[12'h502], mem[12'h501], mem[12'h500]} !== 32'hA1B2C3D4) begin
      fails++;
      $display("FAIL flush_write_bytes: got %h%h%h%h want a1b2c3d4",
               mem[12'h503], mem[12'h502], mem[12'h501], mem[12'h500]);
    end
  endtask

  task automatic test_stall();
    int e = -1, c = 0;
    logic [31:0] v = '0;
    logic [31:0] a_mid = '0;
    d_rw = 1'b0; d_sgn = 1'b1; d_width = 3'd4; d_addr = 32'h100; d_en = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      if (j == 3) a_mid = ram_a;
      if (d_rdy) begin c++; if (e < 0) begin e = j; v = d_rdata; d_en = 1'b0; end end
      if (j == 1) rdy_in = 1'b0;
      if (j == 4) rdy_in = 1'b1;
      if (e >= 0 && j == e + 2) break;
    end
    rdy_in = 1'b1; d_en = 1'b0;
    tests++;
    if (a_mid !== 32'h101) begin
      fails++; $display("FAIL stall_hold_addr: got %h want 00000101", a_mid);
    end
    tests++;
    if (e !== 8 || v !== 32'h12345678 || c !== 1) begin
      fails++; $display("FAIL stall_read: got %h@E%0d x%0d want 12345678@E8 x1", v, e, c);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_arbitration();
    test_flush();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ramctrl.md
# ramctrl

Byte-serial memory controller: the responder end of the data request interface driven by the data controller, plus an instruction-fetch port driven by the instruction cache. It arbitrates the two request sources onto the single 8-bit synchronous RAM bus. It splits 1/2/4-byte accesses into little-endian byte transfers, reassembles and sign/zero-extends read data, and returns a one-cycle ready pulse per request.

## Interface
Parameters:
- none; widths come from `constant.vh`: `AddressWidth` = 32, `IDWidth` = 32.

Ports (clock and reset first):
- clk_in  in  1  clock.
- rst_in  in  1  reset: synchronous, active-high.
- rdy_in  in  1  global clock enable; when low, no register updates.
- rob_rst_in  in  1  pipeline flush.
- datactrl_ramctrl_data_en_in  in  1  data request, level, held until ready is seen.
- datactrl_ramctrl_data_rw_in  in  1  1 = write, 0 = read.
- datactrl_ramctrl_data_sgn_in  in  1  read sign-extend.
- datactrl_ramctrl_data_width_in  in  3  byte count: 1, 2 or 4; any other value is treated as 4.
- datactrl_ramctrl_data_addr_in  in  AddressWidth  byte address; no alignment required.
- datactrl_ramctrl_data_data_in  in  IDWidth  write data.
- ramctrl_datactrl_data_rdy_out  out  1  completion pulse.
- ramctrl_datactrl_data_data_out  out  IDWidth  read result.
- icache_ramctrl_en_in  in  1  fetch request, level, held until ready is seen.
- icache_ramctrl_addr_in  in  AddressWidth  fetch address; always a 4-byte, unsigned read.
- ramctrl_icache_en_out  out  1  fetch completion pulse.
- ramctrl_icache_data_out  out  IDWidth  fetched word.
- ram_data_in  in  8  RAM read byte.
- ram_data_out  out  8  RAM write byte.
- ram_addr_out  out  AddressWidth  RAM byte address.
- ram_rw_out  out  1  1 = write strobe.

## Operation
- Reset: every output register is 0 and the state is IDLE.
- States:
  - IDLE: accept a request.
  - READ: issue addresses and capture bytes.
  - WRITE: drive bytes onto the RAM bus.
  - DONE: one-cycle recovery in which all requests are ignored; then return to IDLE.
- Arbitration in IDLE: the data request has priority over the fetch request. Latch source, rw, sgn, width N, address and write data.
- WRITE:
  - Byte k (data bits 8k+7:8k) goes to address addr+k with ram_rw_out = 1, for k = 0..N-1, one byte per cycle.
  - After the last byte: ram_rw_out returns to 0, the data ready pulse fires, go to DONE.
- READ:
  - Addresses addr..addr+N-1 are issued on consecutive cycles with ram_rw_out = 0.
  - The RAM returns the byte for the address it saw one cycle later. Byte k is therefore captured 2 edges after it was issued.
  - Byte k is placed at bits 8k+7:8k.
  - Zero/sign-extension above bit 8N-1:
    - Sign is bit 7 for N = 1 and bit 15 for N = 2.
    - Extension applies only when sgn = 1 and the source is data.
  - The final byte is merged directly from ram_data_in into the result register on the edge the ready pulse is set.
- Address arithmetic is 32-bit with wrap-around; 0xFFFFFFFF + 1 = 0.
- rob_rst_in (when rdy_in = 1):
  - A read in progress (data or fetch) is aborted: state goes to IDLE, no ready pulse, ram_rw_out = 0.
  - A write in progress always completes all bytes and still emits its ready pulse, because it is a committed store.
  - No request is accepted on a cycle with rob_rst_in high.
- rdy_in low: all state, counters and outputs hold. The RAM is stalled by the same enable at top level, so holding is sufficient.
- Result data registers keep their value after the pulse until the next completion of the same port.

## Timing
- Let E0 be the edge at which a request is accepted in IDLE.
- Write, N bytes:
  - Byte k is on the bus from edge Ek to edge Ek+1.
  - At EN: ram_rw_out ← 0 and rdy ← 1.
  - At EN+1: rdy ← 0, state → IDLE.
  - Latency N edges; the next acceptance is possible at EN+2.
- Read, N bytes:
  - ram_addr_out = addr+k from edge Ek.
  - Byte k is captured at Ek+2.
  - Result and rdy are set at EN+1; rdy drops at EN+2.
  - Latency N+1 edges.
- Ready pulses are exactly one cycle wide. The requester deasserts en on the edge after seeing ready; DONE guarantees that still-high en is not re-accepted.
- Throughput per request: N+2 cycles for a write, N+3 cycles for a read.

## Test plan
- Reset: assert rst_in for 2 cycles with requests active -> all outputs 0 and no RAM write while in reset.
- Word write of 0x12345678 to 0x100 -> 0x78@0x100, 0x56@0x101, 0x34@0x102, 0x12@0x103. ram_rw_out is high for exactly 4 cycles and the data ready pulse lasts 1 cycle at E4.
- Reads from RAM bytes 0x80@0x200 and 0x80,0x01@0x300..0x301:
  - Byte, sgn = 1 -> 0xFFFFFF80; sgn = 0 -> 0x00000080.
  - Halfword 0x0180 read at 0x300, signed -> 0x00000180.
  - Halfword at 0x301 with byte 0x80@0x302, signed -> 0xFFFF8001.
  - Ready appears at E2 (byte) and E3 (halfword).
- Data and fetch requests raised in the same cycle -> the data access completes first. Then, after DONE, the fetch of bytes 0x13,0x00,0x00,0x00 returns 0x00000013 with a 1-cycle ramctrl_icache_en_out.
- rob_rst_in at E2 of a word read -> no ready pulse and ram_rw_out = 0; a new request is accepted the next cycle. rob_rst_in at E1 of a word write -> all 4 bytes are written and ready still fires at E4.
- rdy_in low for 3 cycles in the middle of a word read (with the RAM stalled) -> outputs hold, and the correct word is returned 3 cycles later than nominal.
